// File: rtl/seg7_capture.sv
// Two-digit seven-segment snooper: debounces each strobed digit, decodes it to BCD
// and publishes the low/high pair. SEG7_CAPTURE_ACTIVE_LOW_EN inverts seg_in first.
module seg7_capture #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  input  logic       clear,
  output logic [3:0] bcd_hi,
  output logic [3:0] bcd_lo,
  output logic       valid,
  output logic       err,
  output logic [7:0] led
);
  typedef enum logic [1:0] {CAP_LO, CAP_HI, PUB} state_t;

  localparam logic [3:0] SC = 4'(STABLE_CNT);

  state_t     state, state_n;
  logic [6:0] seg_v, seg_q;
  logic [1:0] sel_q, exp_sel;
  logic [3:0] cnt, cnt_n, cnt_inc, hold_lo, hold_hi, dig;
  logic       match, illegal, commit, lo_ld, hi_ld, pub, err_set;

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  assign seg_v = ~seg_in;
`else
  assign seg_v = seg_in;
`endif

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'b0111111: decode = 4'd0;
      7'b0000110: decode = 4'd1;
      7'b1011011: decode = 4'd2;
      7'b1001111: decode = 4'd3;
      7'b1100110: decode = 4'd4;
      7'b1101101: decode = 4'd5;
      7'b1111101: decode = 4'd6;
      7'b0000111: decode = 4'd7;
      7'b1111111: decode = 4'd8;
      7'b1100111: decode = 4'd9;
      default:    decode = 4'hF;
    endcase
  endfunction

  assign dig     = decode(seg_v);
  assign exp_sel = (state == CAP_LO) ? 2'b01 : (state == CAP_HI) ? 2'b10 : 2'b00;
  assign match   = (state != PUB) && (dig_sel == exp_sel);
  assign illegal = (dig_sel == 2'b11);

  // A run restarts whenever the pattern changes or the strobe has just arrived.
  always_comb begin
    cnt_inc = 4'd0;
    if (match) begin
      if (seg_v != seg_q || sel_q != dig_sel) cnt_inc = 4'd1;
      else if (cnt == SC)                     cnt_inc = cnt;
      else                                    cnt_inc = cnt + 4'd1;
    end
  end

  assign commit = match && (cnt_inc == SC);

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    lo_ld   = 1'b0;
    hi_ld   = 1'b0;
    pub     = 1'b0;
    err_set = illegal;
    if (!illegal) begin
      case (state)
        CAP_LO: if (commit) begin lo_ld = 1'b1; cnt_n = 4'd0; state_n = CAP_HI; end
        CAP_HI: if (commit) begin hi_ld = 1'b1; cnt_n = 4'd0; state_n = PUB; end
        PUB:    begin pub = 1'b1; state_n = CAP_LO; end
        default: state_n = CAP_LO;
      endcase
      if (commit && dig == 4'hF) err_set = 1'b1;
    end
    if (clear) begin
      state_n = CAP_LO;
      cnt_n   = 4'd0;
      lo_ld   = 1'b0;
      hi_ld   = 1'b0;
      pub     = 1'b0;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CAP_LO;
      cnt     <= 4'd0;
      seg_q   <= 7'd0;
      sel_q   <= 2'd0;
      hold_lo <= 4'd0;
      hold_hi <= 4'd0;
      bcd_lo  <= 4'd0;
      bcd_hi  <= 4'd0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      seg_q <= seg_v;
      sel_q <= dig_sel;
      if (lo_ld) hold_lo <= dig;
      if (hi_ld) hold_hi <= dig;
      if (pub) begin
        bcd_lo <= hold_lo;
        bcd_hi <= hold_hi;
      end
      valid <= pub;
      err   <= clear ? 1'b0 : (err | err_set);
    end
  end

  assign led = {bcd_hi, bcd_lo};
endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CNT, default 4, is the number of consecutive identical samples required to accept a digit; legal values are 2..15.
REQ-002 clk  input  1  is the single system clock, and all state changes on its rising edge.
REQ-003 rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 seg_in  input  7  carries the observed segment pattern: bit0=a .. bit6=g, active-high.
REQ-005 dig_sel  input  2  carries the digit strobes: 2'b01 selects the low digit, 2'b10 the high digit, 2'b00 is idle and 2'b11 is illegal.
REQ-006 clear  input  1  is a synchronous abort that returns the FSM to CAP_LO and zeroes the stability counter.
REQ-007 bcd_hi  output  4  carries the last published high digit, with 4'hF meaning an unrecognised pattern.
REQ-008 bcd_lo  output  4  carries the last published low digit, with 4'hF meaning an unrecognised pattern.
REQ-009 valid  output  1  is a one-cycle pulse that marks a new {bcd_hi,bcd_lo} pair.
REQ-010 err  output  1  is a sticky flag for an unrecognised pattern or an illegal strobe, cleared only by clear or reset.
REQ-011 led  output  8  mirrors {bcd_hi,bcd_lo} at all times.

Function
REQ-012 The decode table shall be: 0=7'b0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111; any other pattern decodes to 4'hF.
REQ-013 The FSM states shall be CAP_LO, CAP_HI and PUB, and CAP_LO shall be entered after reset.
REQ-014 Stability counter rules:
- Each cycle, seg_in and dig_sel are registered into sample registers.
- The counter is set to 1 when the current strobe is the one expected by the state and seg_in differs from the previous sample or the strobe was not active on the previous cycle.
- Otherwise the counter increments, saturating at STABLE_CNT.
- Any other strobe value sets the counter to 0.
REQ-015 In CAP_LO, on the edge where the counter reaches STABLE_CNT with dig_sel==2'b01, the decoded value shall be stored in the low holding register, the counter cleared, and the FSM moved to CAP_HI.
REQ-016 In CAP_HI, the same action with dig_sel==2'b10 shall store the high holding register and move the FSM to PUB.
REQ-017 In PUB, bcd_hi and bcd_lo shall load from the holding registers, valid shall be 1 for exactly that cycle, and the FSM shall return to CAP_LO.
REQ-018 Latency from the first matching sample of the high digit to valid shall be STABLE_CNT+1 cycles.
REQ-019 Strobe for the non-expected digit shall be ignored apart from zeroing the counter, and shall not set err.
REQ-020 dig_sel==2'b11 in any state shall set err, zero the counter, and leave the state unchanged.
REQ-021 Committing a digit that decodes to 4'hF shall set err and still be published.
REQ-022 clear takes priority over every other event in the same cycle, including a commit or PUB.
REQ-023 When clear and PUB coincide, valid shall stay 0 and the outputs shall keep their old values.
REQ-024 bcd_hi and bcd_lo shall change only in PUB.

Reset
REQ-025 While rst_n is low, the FSM shall be in CAP_LO, the counter and sample registers 0, bcd_hi=bcd_lo=4'h0, led=8'h00, valid=0 and err=0.
REQ-026 Reset asserted mid-capture shall discard partial holding registers, and no valid shall follow reset release until a full low/high sequence completes.

Configuration
REQ-027 Macro SEG7_CAPTURE_ACTIVE_LOW_EN selects the segment polarity.
- When defined, seg_in is inverted before sampling, for common-anode active-low displays; the decode table of REQ-012 applies to the inverted value.
- When undefined, seg_in is used as-is.

Verification
REQ-028 Low-digit strobe with 1001111 for 4 cycles, then high-digit strobe with 0000111 for 4 cycles -> valid pulses once, bcd_hi=7, bcd_lo=3, led=8'h73, err=0.
REQ-029 Low-digit pattern toggling between the patterns for 3 and 5 every 2 cycles for 20 cycles -> no commit, FSM stays in CAP_LO, valid never asserts.
REQ-030 dig_sel=2'b11 for 1 cycle during CAP_HI -> err=1, state stays CAP_HI, and a subsequent stable high digit still publishes.
REQ-031 Low digit 7'b1010101 stable for 4 cycles, then high digit 0 stable -> bcd_lo=4'hF, bcd_hi=0, err=1, valid pulses.
REQ-032 clear asserted in the PUB cycle -> valid=0, outputs unchanged, state CAP_LO, err=0.
REQ-033 rst_n low for 1 cycle mid-CAP_HI -> all outputs 0 asynchronously, and the next valid requires a fresh low then high capture.
